// File: rtl/if_fetch_ctrl.sv
// Instruction fetch controller: drives the PC register, issues instruction-memory
// requests and buffers returned words in a 2-entry queue toward decode.
module if_fetch_ctrl #(
    parameter int unsigned  N        = 32,
    parameter logic [N-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst,
    output logic [N-1:0] pc_next,
    output logic         pc_load,
    output logic         imem_req,
    output logic [N-1:0] imem_addr,
    input  logic         imem_ack,
    input  logic [31:0]  imem_rdata,
    input  logic         redirect,
    input  logic [N-1:0] redirect_target,
    output logic         inst_valid,
    output logic [31:0]  inst_out,
    output logic [N-1:0] inst_pc,
    input  logic         dec_ready
);

    typedef enum logic [1:0] {
        START,
        REQ,
        BLOCK,
        DROP
    } state_e;

    state_e       state_q, state_d;
    logic [N-1:0] fa_q;
    logic [N-1:0] drop_addr_q;

    logic [31:0]  q_inst_q [2];
    logic [N-1:0] q_pc_q   [2];
    logic         rd_ptr_q, wr_ptr_q;
    logic [1:0]   cnt_q, cnt_d;

    logic         accept;
    logic         enq;
    logic         deq;

    // Redirect flushes the queue, so it also suppresses the dequeue in that cycle.
    assign accept     = (state_q == REQ) && imem_ack && !redirect;
    assign enq        = accept;
    assign inst_valid = (cnt_q != 2'd0);
    assign deq        = inst_valid && dec_ready && !redirect;
    assign inst_out   = q_inst_q[rd_ptr_q];
    assign inst_pc    = q_pc_q[rd_ptr_q];

    always_comb begin
        if (redirect) begin
            cnt_d = 2'd0;
        end else begin
            cnt_d = cnt_q + {1'b0, enq} - {1'b0, deq};
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= START;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            START: state_d = REQ;
            REQ: begin
                if (redirect) begin
                    state_d = imem_ack ? REQ : DROP;
                end else if (imem_ack) begin
                    state_d = (cnt_d <= 2'd1) ? REQ : BLOCK;
                end
            end
            BLOCK: begin
                if (redirect || deq) begin
                    state_d = REQ;
                end
            end
            DROP: begin
                if (imem_ack) begin
                    state_d = REQ;
                end
            end
            default: state_d = START;
        endcase
    end

    // Output logic
    always_comb begin
        imem_req  = (state_q == REQ) || (state_q == DROP);
        imem_addr = (state_q == DROP) ? drop_addr_q : fa_q;
        pc_load   = !rst && (redirect || accept);
        pc_next   = redirect ? {redirect_target[N-1:2], 2'b00} : fa_q + N'(4);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fa_q        <= RESET_PC;
            drop_addr_q <= '0;
        end else begin
            if (pc_load) begin
                fa_q <= pc_next;
            end
            if ((state_q == REQ) && redirect && !imem_ack) begin
                drop_addr_q <= fa_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 2; i++) begin
                q_inst_q[i] <= '0;
                q_pc_q[i]   <= '0;
            end
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            cnt_q <= cnt_d;
            if (redirect) begin
                rd_ptr_q <= 1'b0;
                wr_ptr_q <= 1'b0;
            end else begin
                if (enq) begin
                    q_inst_q[wr_ptr_q] <= imem_rdata;
                    q_pc_q[wr_ptr_q]   <= fa_q;
                    wr_ptr_q           <= ~wr_ptr_q;
                end
                if (deq) begin
                    rd_ptr_q <= ~rd_ptr_q;
                end
            end
        end
    end

endmodule

// File: doc/if_fetch_ctrl.md
IF_FETCH_CTRL -- requirements
Module: if_fetch_ctrl

Interface
REQ-001 Parameter: N, 32, datapath and address width in bits.
REQ-002 Parameter: RESET_PC, 0, fetch address after reset; SHALL equal the reset value of the downstream PC register.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 pc_next  output  N  next PC value presented to the PC register Data input.
REQ-006 pc_load  output  1  load strobe for the PC register.
REQ-007 imem_req  output  1  instruction-memory request.
REQ-008 imem_addr  output  N  request address.
REQ-009 imem_ack  input  1  one-cycle response strobe; imem_rdata valid in the same cycle.
REQ-010 imem_rdata  input  32  fetched instruction word.
REQ-011 redirect  input  1  branch/jump taken, one-cycle pulse.
REQ-012 redirect_target  input  N  new fetch PC.
REQ-013 inst_valid  output  1  queue head valid toward decode.
REQ-014 inst_out  output  32  queue head instruction.
REQ-015 inst_pc  output  N  PC of queue head.
REQ-016 dec_ready  input  1  decode accepts head this cycle.

Function
REQ-017 Internal fetch-address register fa SHALL mirror the PC register: reset to RESET_PC and load pc_next whenever pc_load=1.
REQ-018 pc_load SHALL be combinational: 1 on redirect or on an accepted ack, else 0; pc_next = redirect ? {redirect_target[N-1:2],2'b00} : fa+4 (mod 2^N, wraps to 0).
REQ-019 Instruction queue SHALL be 2-entry FIFO of {inst, pc}; inst_valid = occupancy>0; inst_out/inst_pc = head; dequeue when inst_valid & dec_ready.
REQ-020 FSM states: START, REQ, BLOCK, DROP; imem_req=1 only in REQ and DROP.
REQ-021 START: imem_req=0; next state REQ unconditionally.
REQ-022 REQ: imem_addr=fa; imem_req and imem_addr held stable until imem_ack.
REQ-023 REQ, ack without redirect: enqueue {imem_rdata, fa}, pc_load=1; next REQ if occupancy after this cycle's enqueue/dequeue <=1, else BLOCK.
REQ-024 BLOCK: imem_req=0; next REQ in the cycle a dequeue occurs.
REQ-025 Redirect (all states) SHALL have highest priority: flush queue at the same edge (inst_valid=0 next cycle, regardless of dec_ready), pc_load=1, fa<=aligned target.
REQ-026 Redirect in REQ with imem_ack=0: capture fa into drop_addr, next DROP; with imem_ack=1: rdata discarded, next REQ.
REQ-027 DROP: imem_req=1, imem_addr=drop_addr; ack data discarded, no pc_load unless redirect; on ack next REQ; redirect in DROP updates fa only, stays DROP until ack.
REQ-028 Redirect in START/BLOCK: next REQ.
REQ-029 Throughput: with zero-wait memory and dec_ready=1, one instruction per cycle; first request cycle after reset is cycle 2.
REQ-030 Queue SHALL never overflow and SHALL never dequeue when empty.

Reset
REQ-031 During rst: state=START, fa=RESET_PC, queue empty, drop_addr=0, imem_req=0, pc_load=0, inst_valid=0, inst_out=0, inst_pc=0.
REQ-032 Reset asserted mid-request SHALL immediately drop imem_req; the outstanding response is abandoned.

Verification
REQ-033 Reset release, imem_ack every request cycle, dec_ready=1 -> imem_addr 0x0,0x4,0x8 on consecutive cycles; inst_pc follows one cycle later; pc_next=fa+4 with pc_load=1 each ack.
REQ-034 dec_ready=0 with immediate acks -> two entries enqueued, FSM in BLOCK, imem_req=0; dec_ready=1 one cycle -> REQ re-entered, no word lost or duplicated.
REQ-035 Redirect to 0x103 while request at 0x40 outstanding, ack 3 cycles later -> pc_next=0x100, DROP holds imem_addr=0x40, ack data discarded, next request 0x100.
REQ-036 Redirect and imem_ack same cycle -> rdata discarded, queue flushed, pc_next=target, next request at target.
REQ-037 fa=0xFFFFFFFC, ack -> pc_next=0x00000000, pc_load=1.
REQ-038 rst asserted with 2 queued entries and request pending -> inst_valid=0, imem_req=0 asynchronously; after release first request at RESET_PC.
